// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int FIFO_RD_BUF_DEPTH = 2;
    localparam int FIFO_RD_LVL_W     = $clog2(FIFO_RD_BUF_DEPTH + 1);
    localparam int FIFO_XFER_CNT_W   = 16;

    // Output buffer occupancy; the encoding is the occupancy value itself.
    typedef enum logic [FIFO_RD_LVL_W-1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL2 = 2'd2
    } buf_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order output buffer; the head entry drives the stream data.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    head_data,
    output logic [FIFO_RD_LVL_W-1:0] count
);

    localparam int IDX_W = $clog2(FIFO_RD_BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_RD_BUF_DEPTH];
    logic [IDX_W-1:0]      head_idx;
    logic [IDX_W-1:0]      tail_idx;
    buf_state_e            state;
    buf_state_e            state_next;
    logic                  do_push;
    logic                  do_pop;

    // Pushing into a full buffer or popping an empty one is dropped rather than corrupting order.
    assign do_push = push && ((state != BUF_FULL2) || pop);
    assign do_pop  = pop && (state != BUF_EMPTY);

    always_comb begin
        state_next = state;
        case (state)
            BUF_EMPTY: if (do_push) state_next = BUF_ONE;
            BUF_ONE: begin
                if (do_push && !do_pop)      state_next = BUF_FULL2;
                else if (!do_push && do_pop) state_next = BUF_EMPTY;
            end
            BUF_FULL2: if (do_pop && !do_push) state_next = BUF_ONE;
            default:   state_next = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BUF_EMPTY;
            head_idx <= '0;
            tail_idx <= '0;
            for (int i = 0; i < FIFO_RD_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (do_push) begin
                mem[tail_idx] <= push_data;
                tail_idx      <= tail_idx + 1'b1;
            end
            if (do_pop) begin
                head_idx <= head_idx + 1'b1;
            end
        end
    end

    assign head_data = mem[head_idx];
    assign count     = state;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the synchronous FIFO (one-cycle read latency) and presents words as a valid/ready stream.
// Optional accepted-word counter on xfer_cnt when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_empty,
    input  logic [DATA_WIDTH-1:0]    fifo_rdout,
    output logic                     fifo_ren,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic [FIFO_RD_LVL_W-1:0] level
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [FIFO_XFER_CNT_W-1:0] xfer_cnt
`endif
);

    localparam logic [FIFO_RD_LVL_W:0] DEPTH_L = (FIFO_RD_LVL_W + 1)'(FIFO_RD_BUF_DEPTH);

    logic                     inflight;
    logic                     pop_out;
    logic [FIFO_RD_LVL_W-1:0] count;
    logic [FIFO_RD_LVL_W:0]   committed;

    stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_data(fifo_rdout),
        .pop      (pop_out),
        .head_data(m_data),
        .count    (count)
    );

    assign m_valid = (count != '0);
    assign pop_out = m_valid && m_ready;
    assign level   = count;

    // Words held plus the word still in the FIFO read pipe; a slot freed this cycle may be refilled.
    assign committed = {1'b0, count} + {{FIFO_RD_LVL_W{1'b0}}, inflight};
    assign fifo_ren  = !fifo_empty && ((committed < DEPTH_L) || ((committed == DEPTH_L) && pop_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_ren;
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (pop_out) begin
            xfer_cnt <= xfer_cnt + FIFO_XFER_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream with a queue-based FIFO model and a stream scoreboard.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdout;
    logic          fifo_ren;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    level;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0]   xfer_cnt;
`endif

    fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_rdout(fifo_rdout),
        .fifo_ren  (fifo_ren),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .level     (level)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rdy;
        logic          exp_ren;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_level;
    } vec_t;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    vec_t          vecs[$];
    int            popped_total;
    int            accepted_total;
    logic          last_ren;
    logic          underflow;
    logic          prev_valid;
    logic          prev_ready;
    logic [DW-1:0] prev_data;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // FIFO model: pops on the rising edge, read data appears one cycle later.
    task automatic clockEdge();
        logic [DW-1:0] w;
        @(posedge clk);
        last_ren = fifo_ren;
        if (fifo_ren) begin
            if (fifo_q.size() == 0) begin
                underflow = 1'b1;
            end else begin
                w = fifo_q.pop_front();
                fifo_rdout <= w;
                popped_total++;
            end
        end
        if (m_valid && m_ready) accepted_total++;
        fifo_empty <= (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic rdy, input logic wr, input logic [DW-1:0] wd);
        m_ready = rdy;
        if (wr) begin
            fifo_q.push_back(wd);
            exp_q.push_back(wd);
        end
        fifo_empty = (fifo_q.size() == 0);
        #1;
    endtask

    task automatic clearModel();
        fifo_q.delete();
        exp_q.delete();
        fifo_empty     = 1'b1;
        fifo_rdout     = '0;
        popped_total   = 0;
        accepted_total = 0;
        last_ren       = 1'b0;
        underflow      = 1'b0;
        prev_valid     = 1'b0;
        prev_ready     = 1'b0;
        prev_data      = '0;
    endtask

    task automatic resetDut();
        rst_n   = 1'b0;
        m_ready = 1'b0;
        clearModel();
        clockEdge();
        clockEdge();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic preload(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
    endtask

    function automatic void addVec(input logic rdy, input logic ren, input logic v,
                                   input logic [DW-1:0] d, input logic [1:0] lvl);
        vec_t e;
        e.rdy = rdy; e.exp_ren = ren; e.exp_valid = v; e.exp_data = d; e.exp_level = lvl;
        vecs.push_back(e);
    endfunction

    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) clockEdge();
            applyStimulus(vecs[i].rdy, 1'b0, '0);
            checkOutput($sformatf("%s[%0d] fifo_ren", tag, i), 32'(fifo_ren), 32'(vecs[i].exp_ren));
            checkOutput($sformatf("%s[%0d] m_valid", tag, i), 32'(m_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("%s[%0d] level", tag, i), 32'(level), 32'(vecs[i].exp_level));
            if (vecs[i].exp_valid)
                checkOutput($sformatf("%s[%0d] m_data", tag, i), 32'(m_data), 32'(vecs[i].exp_data));
        end
        vecs.delete();
    endtask

    // Occupancy must equal words popped minus words accepted minus the word still in the read pipe.
    task automatic checkInvariants();
        checkOutput("level bound", 32'(level <= 2'd2), 32'd1);
        checkOutput("level conservation", 32'(level), 32'(popped_total - accepted_total - int'(last_ren)));
        checkOutput("valid vs level", 32'(m_valid), 32'(level != 2'd0));
        if (prev_valid && !prev_ready) begin
            checkOutput("stall hold valid", 32'(m_valid), 32'd1);
            checkOutput("stall hold data", 32'(m_data), 32'(prev_data));
        end
        prev_valid = m_valid;
        prev_ready = m_ready;
        prev_data  = m_data;
    endtask

    initial begin
        int got;
        int n;
        int written;
        logic [DW-1:0] want;

        // Reset state with the FIFO empty.
        rst_n   = 1'b0;
        m_ready = 1'b0;
        clearModel();
        #1;
        checkOutput("reset fifo_ren", 32'(fifo_ren), 32'd0);
        checkOutput("reset m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset level", 32'(level), 32'd0);
        checkOutput("reset m_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        checkOutput("reset xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
        clockEdge();
        clockEdge();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clockEdge();
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("idle fifo_ren", 32'(fifo_ren), 32'd0);
            checkOutput("idle m_valid", 32'(m_valid), 32'd0);
        end

        // Three preloaded words, sink always ready.
        resetDut();
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
        addVec(1, 1, 0, 8'h00, 0);
        addVec(1, 1, 0, 8'h00, 0);
        addVec(1, 1, 1, 8'h11, 1);
        addVec(1, 0, 1, 8'h22, 1);
        addVec(1, 0, 1, 8'h33, 1);
        addVec(1, 0, 0, 8'h00, 0);
        addVec(1, 0, 0, 8'h00, 0);
        runTable("burst3");

        // Eight words with the sink stalled from the start, then released.
        resetDut();
        preload(8, 8'hA0);
        addVec(0, 1, 0, 8'h00, 0);
        addVec(0, 1, 0, 8'h00, 0);
        addVec(0, 0, 1, 8'hA0, 1);
        addVec(0, 0, 1, 8'hA0, 2);
        addVec(0, 0, 1, 8'hA0, 2);
        addVec(1, 1, 1, 8'hA0, 2);
        for (int i = 1; i <= 5; i++) addVec(1, 1, 1, 8'hA0 + DW'(i), 1);
        addVec(1, 0, 1, 8'hA6, 1);
        addVec(1, 0, 1, 8'hA7, 1);
        addVec(1, 0, 0, 8'h00, 0);
        runTable("stall8");
        checkOutput("stall8 underflow", 32'(underflow), 32'd0);

        // Reset while a read is in flight and one word is buffered.
        resetDut();
        preload(3, 8'h40);
        applyStimulus(1'b1, 1'b0, '0);
        clockEdge();
        applyStimulus(1'b1, 1'b0, '0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("pre-reset level", 32'(level), 32'd1);
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("async reset fifo_ren", 32'(fifo_ren), 32'd0);
        checkOutput("async reset m_valid", 32'(m_valid), 32'd0);
        checkOutput("async reset level", 32'(level), 32'd0);
        checkOutput("async reset m_data", 32'(m_data), 32'd0);
        clockEdge();
        clockEdge();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clockEdge();
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("post-reset stale m_valid", 32'(m_valid), 32'd0);
            checkOutput("post-reset level", 32'(level), 32'd0);
        end

        // Random writes and random sink readiness against the scoreboard.
        resetDut();
        got = 0;
        written = 0;
        n = 0;
        while (got < 1000 && n < 20000) begin
            logic wr;
            clockEdge();
            wr = 1'($urandom_range(1, 0)) && (written < 1000);
            if (wr) written++;
            applyStimulus(1'($urandom_range(1, 0)), wr, DW'($urandom));
            checkInvariants();
`ifdef FIFO_RD_STREAM_CNT_EN
            checkOutput("xfer_cnt tracks accepts", 32'(xfer_cnt), 32'(accepted_total[15:0]));
`endif
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious word", 32'd1, 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    checkOutput("stream order", 32'(m_data), 32'(want));
                end
                got++;
            end
            n++;
        end
        checkOutput("random words delivered", 32'(got), 32'd1000);
        checkOutput("random underflow", 32'(underflow), 32'd0);

`ifdef FIFO_RD_STREAM_CNT_EN
        // Counter wraps after 65536 accepted words.
        resetDut();
        preload(65537, 8'h00);
        applyStimulus(1'b1, 1'b0, '0);
        n = 0;
        while (accepted_total < 65537 && n < 70000) begin
            clockEdge();
            applyStimulus(1'b1, 1'b0, '0);
            n++;
        end
        checkOutput("wrap accepted words", 32'(accepted_total), 32'd65537);
        checkOutput("wrap throughput", 32'(n < 65600), 32'd1);
        checkOutput("xfer_cnt wrap", 32'(xfer_cnt), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
